// File: rtl/sephirot_rf_pkg.sv
// Shared definitions for the sephirot register-file write-back path.
package sephirot_rf_pkg;

  localparam int COLL_CNT_W = 16;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } wb_state_e;

  // Ceiling log2, never below 1 so that address/count fields keep a bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/wb_collision_resolve.sv
// Same-cycle address collision resolver: among valid lanes aiming at the
// same address only the highest-index lane keeps its enable.
module wb_collision_resolve #(
  parameter int NLANES = 2,
  parameter int ADDRW  = 4,
  parameter int SUPW   = 2
) (
  input  logic [NLANES-1:0]       valid_i,
  input  logic [ADDRW*NLANES-1:0] addr_i,
  output logic [NLANES-1:0]       en_o,
  output logic [SUPW-1:0]         supp_cnt_o
);

  // A lane is suppressed when any higher lane is valid with the same address.
  always_comb begin
    en_o       = '0;
    supp_cnt_o = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (valid_i[i]) begin
        en_o[i] = 1'b1;
        for (int j = 0; j < NLANES; j++) begin
          if ((j > i) && valid_i[j] &&
              (addr_i[j*ADDRW +: ADDRW] == addr_i[i*ADDRW +: ADDRW])) begin
            en_o[i] = 1'b0;
          end
        end
        if (!en_o[i]) begin
          supp_cnt_o = supp_cnt_o + SUPW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller in front of the multi-port LVT register file:
// registers lane writes onto the write ports, resolves same-address lane
// collisions, forwards in-flight writes to the read ports and sequences a
// zero-clear of the whole register file after reset or on request.
module regfile_wb_ctrl
  import sephirot_rf_pkg::*;
#(
  parameter int   MEMD       = 16,
  parameter int   DATAW      = 64,
  parameter int   nWPORTS    = 2,
  parameter int   nRPORTS    = 2,
  parameter bit   INIT_CLEAR = 1'b1,
  localparam int  ADDRW      = clog2(MEMD)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_req,
  input  logic [nWPORTS-1:0]       lane_valid,
  input  logic [ADDRW*nWPORTS-1:0] lane_addr,
  input  logic [DATAW*nWPORTS-1:0] lane_data,
  output logic                     lane_ready,
  output logic [nWPORTS-1:0]       WEnb,
  output logic [ADDRW*nWPORTS-1:0] WAddr,
  output logic [DATAW*nWPORTS-1:0] WData,
  input  logic [ADDRW*nRPORTS-1:0] RAddr,
  input  logic [DATAW*nRPORTS-1:0] RDataMem,
  output logic [DATAW*nRPORTS-1:0] RData,
  output logic                     busy,
  output logic [COLL_CNT_W-1:0]    collision_cnt
);

  localparam int SUPW = clog2(nWPORTS + 1);

  wb_state_e                  state_q, state_d;
  logic [ADDRW-1:0]           clr_q, clr_d;
  logic [nWPORTS-1:0]         wenb_q, wenb_d;
  logic [ADDRW*nWPORTS-1:0]   waddr_q, waddr_d;
  logic [DATAW*nWPORTS-1:0]   wdata_q, wdata_d;
  logic [COLL_CNT_W-1:0]      coll_q, coll_d;
  logic [nWPORTS-1:0]         lane_acc;
  logic [nWPORTS-1:0]         lane_en;
  logic [SUPW-1:0]            lane_supp;

  function automatic logic [COLL_CNT_W-1:0] sat_add(
    input logic [COLL_CNT_W-1:0] a,
    input logic [SUPW-1:0]       b
  );
    logic [COLL_CNT_W:0] sum;
    sum = {1'b0, a} + (COLL_CNT_W + 1)'(b);
    return sum[COLL_CNT_W] ? '1 : sum[COLL_CNT_W-1:0];
  endfunction

  // A clear request takes priority, so lane writes in that cycle are refused.
  assign lane_ready = (state_q == ST_RUN) && !clear_req;
  assign lane_acc   = lane_valid & {nWPORTS{lane_ready}};
  assign busy       = (state_q == ST_CLEAR);

  // Collisions are resolved only among writes actually accepted this cycle.
  wb_collision_resolve #(
    .NLANES (nWPORTS),
    .ADDRW  (ADDRW),
    .SUPW   (SUPW)
  ) u_coll (
    .valid_i    (lane_acc),
    .addr_i     (lane_addr),
    .en_o       (lane_en),
    .supp_cnt_o (lane_supp)
  );

  // Next-state: clear walk on port 0, or resolved lane writes in RUN.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    wenb_d  = '0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    coll_d  = coll_q;
    case (state_q)
      ST_CLEAR: begin
        wenb_d[0]              = 1'b1;
        waddr_d[0 +: ADDRW]    = clr_q;
        wdata_d[0 +: DATAW]    = '0;
        if (clear_req) begin
          clr_d = '0;
        end else if (clr_q == ADDRW'(MEMD - 1)) begin
          clr_d   = '0;
          state_d = ST_RUN;
        end else begin
          clr_d = clr_q + ADDRW'(1);
        end
      end
      default: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          clr_d   = '0;
        end else begin
          for (int w = 0; w < nWPORTS; w++) begin
            if (lane_en[w]) begin
              wenb_d[w]                  = 1'b1;
              waddr_d[w*ADDRW +: ADDRW]  = lane_addr[w*ADDRW +: ADDRW];
              wdata_d[w*DATAW +: DATAW]  = lane_data[w*DATAW +: DATAW];
            end
          end
          coll_d = sat_add(coll_q, lane_supp);
        end
      end
    endcase
  end

  // State, clear counter and the single write-port register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT_CLEAR ? ST_CLEAR : ST_RUN;
      clr_q   <= '0;
      wenb_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      coll_q  <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      wenb_q  <= wenb_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      coll_q  <= coll_d;
    end
  end

  assign WEnb          = wenb_q;
  assign WAddr         = waddr_q;
  assign WData         = wdata_q;
  assign collision_cnt = coll_q;

  // Read forwarding: the highest write port hitting the read address wins.
  always_comb begin
    RData = RDataMem;
    for (int r = 0; r < nRPORTS; r++) begin
      for (int w = 0; w < nWPORTS; w++) begin
        if (wenb_q[w] && (waddr_q[w*ADDRW +: ADDRW] == RAddr[r*ADDRW +: ADDRW])) begin
          RData[r*DATAW +: DATAW] = wdata_q[w*DATAW +: DATAW];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Testbench for regfile_wb_ctrl with a register-file model and a
// write-back reference model.
module tb_regfile_wb_ctrl;

  localparam int MEMD = 16;
  localparam int DW   = 64;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_req;
  logic [1:0]    lane_valid;
  logic [7:0]    lane_addr;
  logic [127:0]  lane_data;
  logic [7:0]    RAddr;
  logic [127:0]  RDataMem;

  logic          lane_ready, busy;
  logic [1:0]    WEnb;
  logic [7:0]    WAddr;
  logic [127:0]  WData, RData;
  logic [15:0]   collision_cnt;

  logic          lane_ready_z, busy_z;
  logic [1:0]    WEnb_z;
  logic [7:0]    WAddr_z;
  logic [127:0]  WData_z, RData_z;
  logic [15:0]   collision_cnt_z;

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] mem  [MEMD];
  logic [63:0] arch [MEMD];

  int          m_clear;
  int          m_clr;
  int          m_cnt;
  logic [1:0]  e_wenb;
  logic [3:0]  e_wa [2];
  logic [63:0] e_wd [2];

  typedef struct {
    logic [1:0]  v;
    logic [3:0]  a0, a1;
    logic [63:0] d0, d1;
    logic        clr;
    logic [3:0]  ra0, ra1;
    logic [63:0] rd0, rd1;
    logic [1:0]  wenb;
    logic [3:0]  wa0, wa1;
    logic [63:0] wd0, wd1;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.MEMD(MEMD), .DATAW(DW), .nWPORTS(2), .nRPORTS(2), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .lane_valid(lane_valid),
    .lane_addr(lane_addr), .lane_data(lane_data), .lane_ready(lane_ready),
    .WEnb(WEnb), .WAddr(WAddr), .WData(WData), .RAddr(RAddr),
    .RDataMem(RDataMem), .RData(RData), .busy(busy), .collision_cnt(collision_cnt)
  );

  regfile_wb_ctrl #(.MEMD(MEMD), .DATAW(DW), .nWPORTS(2), .nRPORTS(2), .INIT_CLEAR(1'b0)) dut_z (
    .clk(clk), .rst(rst), .clear_req(clear_req), .lane_valid(lane_valid),
    .lane_addr(lane_addr), .lane_data(lane_data), .lane_ready(lane_ready_z),
    .WEnb(WEnb_z), .WAddr(WAddr_z), .WData(WData_z), .RAddr(RAddr),
    .RDataMem(RDataMem), .RData(RData_z), .busy(busy_z), .collision_cnt(collision_cnt_z)
  );

  // Register file seen by the main DUT.
  always @(posedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (WEnb[w]) mem[WAddr[w*AW +: AW]] <= WData[w*DW +: DW];
    end
  end

  assign RDataMem = {mem[RAddr[7:4]], mem[RAddr[3:0]]};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clear = 1;
    m_clr   = 0;
    m_cnt   = 0;
    e_wenb  = 2'b00;
    for (int w = 0; w < 2; w++) begin
      e_wa[w] = '0;
      e_wd[w] = '0;
    end
    for (int i = 0; i < MEMD; i++) arch[i] = mem[i];
  endtask

  // One clock cycle: drive at the falling edge, check, advance the model,
  // and return at the next falling edge.
  task automatic cycle(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1, input logic clr,
                       input logic [3:0] ra0, input logic [3:0] ra1,
                       output logic [63:0] rd0, output logic [63:0] rd1);
    logic [3:0]  la [2];
    logic [63:0] ld [2];
    int          owner [int];
    int          supp;
    lane_valid = v;
    lane_addr  = {a1, a0};
    lane_data  = {d1, d0};
    clear_req  = clr;
    RAddr      = {ra1, ra0};
    #1;
    chk("lane_ready", lane_ready, (m_clear == 0) && !clr);
    chk("busy", busy, m_clear != 0);
    chk("WEnb", WEnb, e_wenb);
    chk("WAddr", WAddr, {e_wa[1], e_wa[0]});
    chk("WData", WData, {e_wd[1], e_wd[0]});
    chk("collision_cnt", collision_cnt, m_cnt[15:0]);
    chk("RData0", RData[63:0], arch[ra0]);
    chk("RData1", RData[127:64], arch[ra1]);
    rd0 = RData[63:0];
    rd1 = RData[127:64];
    la[0] = a0; la[1] = a1; ld[0] = d0; ld[1] = d1;
    if (m_clear != 0) begin
      e_wenb   = 2'b01;
      e_wa[0]  = m_clr[3:0];
      e_wd[0]  = '0;
      arch[m_clr] = '0;
      if (clr) m_clr = 0;
      else if (m_clr == MEMD - 1) begin m_clr = 0; m_clear = 0; end
      else m_clr++;
    end else if (clr) begin
      e_wenb  = 2'b00;
      m_clear = 1;
      m_clr   = 0;
    end else begin
      e_wenb = 2'b00;
      for (int w = 0; w < 2; w++) if (v[w]) owner[int'(la[w])] = w;
      foreach (owner[a]) begin
        e_wenb[owner[a]] = 1'b1;
        e_wa[owner[a]]   = la[owner[a]];
        e_wd[owner[a]]   = ld[owner[a]];
        arch[a]          = ld[owner[a]];
      end
      supp  = $countones(v) - owner.num();
      m_cnt = (m_cnt + supp > 65535) ? 65535 : m_cnt + supp;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Idle through a full clear and check each zero write on port 0.
  task automatic clear_walk(input string tag);
    logic [63:0] r0, r1;
    for (int i = 0; i < MEMD; i++) begin
      chk({tag, "_busy"}, busy, 1'b1);
      cycle(2'b00, 4'd0, 4'd0, 64'd0, 64'd0, 1'b0, 4'((i + 15) % 16), 4'd2, r0, r1);
      chk({tag, "_wenb"}, WEnb, 2'b01);
      chk({tag, "_waddr0"}, WAddr[3:0], i[3:0]);
      chk({tag, "_wdata0"}, WData[63:0], 64'd0);
    end
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_ready_end"}, lane_ready, 1'b1);
  endtask

  initial begin
    logic [63:0] r0, r1;
    rst = 1'b1; clear_req = 1'b0; lane_valid = '0; lane_addr = '0;
    lane_data = '0; RAddr = '0;
    tbl[0] = '{2'b11, 4'd3, 4'd7, 64'hA5, 64'h5A, 1'b0, 4'd0, 4'd1, 64'h0,  64'h0,  2'b11, 4'd3, 4'd7, 64'hA5, 64'h5A, 16'd0};
    tbl[1] = '{2'b00, 4'd0, 4'd0, 64'h0,  64'h0,  1'b0, 4'd3, 4'd7, 64'hA5, 64'h5A, 2'b00, 4'd3, 4'd7, 64'hA5, 64'h5A, 16'd0};
    tbl[2] = '{2'b11, 4'd5, 4'd5, 64'd11, 64'd22, 1'b0, 4'd3, 4'd7, 64'hA5, 64'h5A, 2'b10, 4'd3, 4'd5, 64'hA5, 64'd22, 16'd1};
    tbl[3] = '{2'b01, 4'd9, 4'd0, 64'h77, 64'h0,  1'b0, 4'd5, 4'd3, 64'd22, 64'hA5, 2'b01, 4'd9, 4'd5, 64'h77, 64'd22, 16'd1};
    tbl[4] = '{2'b10, 4'd0, 4'd2, 64'h0,  64'h33, 1'b0, 4'd9, 4'd5, 64'h77, 64'd22, 2'b10, 4'd9, 4'd2, 64'h77, 64'h33, 16'd1};
    tbl[5] = '{2'b11, 4'd2, 4'd2, 64'h44, 64'h55, 1'b0, 4'd2, 4'd9, 64'h33, 64'h77, 2'b10, 4'd9, 4'd2, 64'h77, 64'h55, 16'd2};
    tbl[6] = '{2'b01, 4'd4, 4'd0, 64'h99, 64'h0,  1'b1, 4'd2, 4'd4, 64'h55, 64'h0,  2'b00, 4'd9, 4'd2, 64'h77, 64'h55, 16'd2};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_WEnb", WEnb, 2'b00);
    chk("rst_WAddr", WAddr, 8'h00);
    chk("rst_WData", WData, 128'h0);
    chk("rst_cnt", collision_cnt, 16'h0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_ready", lane_ready, 1'b0);
    chk("z_rst_busy", busy_z, 1'b0);
    rst = 1'b0;
    model_reset();

    // Initial clear, with the no-clear instance idling alongside.
    for (int i = 0; i < MEMD; i++) begin
      chk("init_busy", busy, 1'b1);
      chk("z_busy", busy_z, 1'b0);
      chk("z_ready", lane_ready_z, 1'b1);
      chk("z_wenb", WEnb_z, 2'b00);
      cycle(2'b00, 4'd0, 4'd0, 64'd0, 64'd0, 1'b0, 4'((i + 15) % 16), 4'd2, r0, r1);
      chk("z_rdata", RData_z[63:0], arch[(i + 15) % 16]);
      chk("init_wenb", WEnb, 2'b01);
      chk("init_waddr0", WAddr[3:0], i[3:0]);
      chk("init_wdata0", WData[63:0], 64'd0);
    end
    chk("init_busy_end", busy, 1'b0);
    chk("init_ready_end", lane_ready, 1'b1);

    // Directed vectors: writes, forwarding, collision, clear with a lane write.
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, tbl[i].clr,
            tbl[i].ra0, tbl[i].ra1, r0, r1);
      chk($sformatf("vec%0d_rd0", i), r0, tbl[i].rd0);
      chk($sformatf("vec%0d_rd1", i), r1, tbl[i].rd1);
      chk($sformatf("vec%0d_wenb", i), WEnb, tbl[i].wenb);
      chk($sformatf("vec%0d_waddr", i), WAddr, {tbl[i].wa1, tbl[i].wa0});
      chk($sformatf("vec%0d_wdata", i), WData, {tbl[i].wd1, tbl[i].wd0});
      chk($sformatf("vec%0d_cnt", i), collision_cnt, tbl[i].cnt);
      if (i == 0) begin
        chk("z_write_wenb", WEnb_z, 2'b11);
        chk("z_write_waddr", WAddr_z, 8'h73);
        chk("z_write_wdata", WData_z, {64'h5A, 64'hA5});
        chk("z_cnt", collision_cnt_z, 16'h0);
      end
    end
    chk("req_clear_busy", busy, 1'b1);
    clear_walk("reclear");

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] a0, a1;
      a0 = 4'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 4'($urandom_range(0, 15));
      cycle(2'($urandom_range(0, 3)), a0, a1, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 39) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            r0, r1);
    end
    while (m_clear != 0) begin
      cycle(2'b00, 4'd0, 4'd0, 64'd0, 64'd0, 1'b0, 4'd0, 4'd1, r0, r1);
    end

    // Reset in the middle of a clear walk.
    cycle(2'b00, 4'd0, 4'd0, 64'd0, 64'd0, 1'b1, 4'd0, 4'd1, r0, r1);
    for (int i = 0; i < 9; i++) begin
      cycle(2'b00, 4'd0, 4'd0, 64'd0, 64'd0, 1'b0, 4'd0, 4'd1, r0, r1);
    end
    chk("midclr_addr8", WAddr[3:0], 4'd8);
    rst = 1'b1;
    #1;
    chk("midclr_rst_wenb", WEnb, 2'b00);
    chk("midclr_rst_waddr", WAddr, 8'h00);
    chk("midclr_rst_wdata", WData, 128'h0);
    chk("midclr_rst_cnt", collision_cnt, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_walk("rstclear");

    // Saturation of the collision counter.
    for (int n = 0; n < 65540; n++) begin
      cycle(2'b11, 4'd5, 4'd5, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0,
            4'd5, 4'd6, r0, r1);
    end
    chk("sat_cnt", collision_cnt, 16'hFFFF);
    cycle(2'b11, 4'd1, 4'd1, 64'd1, 64'd2, 1'b0, 4'd1, 4'd5, r0, r1);
    chk("sat_cnt_hold", collision_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Write-back controller sitting directly upstream of the sephirot multi-port LVT register file. It collects per-lane results from the VLIW execution lanes and registers them onto the register file's write ports. It resolves same-address collisions between lanes and forwards in-flight writes onto the read ports. After reset or on request, it sequences a zero-clear of the whole register file.

Parameters:
MEMD, 16, register-file depth (entries); ADDRW = $clog2(MEMD)
DATAW, 64, register width in bits
nWPORTS, 2, lanes / register-file write ports
nRPORTS, 2, register-file read ports
INIT_CLEAR, 1, 1 = enter CLEAR after reset; 0 = go straight to RUN

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
clear_req  in  1  one-cycle pulse: re-zero the register file (per-packet start)
lane_valid  in  nWPORTS  per-lane write request
lane_addr  in  ADDRW*nWPORTS  per-lane destination register, lane w at [w*ADDRW +: ADDRW]
lane_data  in  DATAW*nWPORTS  per-lane result data
lane_ready  out  1  lanes may write this cycle
WEnb  out  nWPORTS  register-file write enables (registered)
WAddr  out  ADDRW*nWPORTS  register-file write addresses (registered)
WData  out  DATAW*nWPORTS  register-file write data (registered)
RAddr  in  ADDRW*nRPORTS  read addresses (also routed to the register file)
RDataMem  in  DATAW*nRPORTS  raw read data from the register file
RData  out  DATAW*nRPORTS  read data with forwarding applied
busy  out  1  high while in CLEAR
collision_cnt  out  16  saturating count of suppressed lane writes

Behaviour:
- Reset: WEnb=0, WAddr=0, WData=0, collision_cnt=0, clear counter=0. State = CLEAR if INIT_CLEAR, else RUN.
- Reset asserted mid-CLEAR or mid-RUN aborts everything; no partial write is held.
- FSM CLEAR:
  - Port 0 writes zero to address clr_cnt each cycle: WEnb=1 on port 0, 0 elsewhere.
  - clr_cnt increments 0..MEMD-1.
  - Transition to RUN on the cycle after the write of address MEMD-1. MEMD write cycles total; busy=1 throughout.
  - lane_ready=0; lane_valid is ignored.
  - clear_req during CLEAR restarts clr_cnt at 0.
- FSM RUN:
  - lane_ready = !clear_req (combinational).
  - A lane write accepted in cycle N (lane_valid[w] && lane_ready) appears on WEnb[w]/WAddr/WData in cycle N+1: exactly one register stage.
  - Lanes not valid in N give WEnb[w]=0 in N+1. WAddr/WData hold their last values when not enabled.
  - clear_req in RUN: lane writes that cycle are dropped; CLEAR is entered next cycle with clr_cnt=0.
- Collision, same cycle: lanes i<j both valid with equal addr → the highest-index lane wins. Lower lanes get WEnb=0.
  - collision_cnt += number of suppressed lanes, saturating at 16'hFFFF.
  - This gives the register file at most one writer per address per cycle, so the LVT is never ambiguous.
- Forwarding, combinational, per read port r:
  - If any registered WEnb[w]=1 with WAddr[w]==RAddr[r], RData[r] = WData of the highest such w.
  - Otherwise RData[r] = RDataMem[r].
  - Applies in CLEAR too: the address being cleared forwards zero.
- No other latency: RData has the same timing as RDataMem.

Decomposition:
- Shared package/header sephirot_rf_pkg holds:
  - ADDRW derivation via clog2_function.vh
  - FSM state encodings ST_CLEAR=1'b1, ST_RUN=1'b0
  - COLL_CNT_W=16
- Natural sub-module: wb_collision_resolve. Combinational; takes lane_valid/lane_addr and produces per-lane effective enables plus the suppressed-lane count. It is reused wherever lanes converge on a shared resource.
- Forwarding mux and FSM stay in the top module.

Test Plan:
1. Reset release, MEMD=16, INIT_CLEAR=1 → busy=1 for 16 cycles; WEnb=2'b01 with WAddr[0]=0..15 and WData[0]=0; then busy=0 and lane_ready=1.
2. RUN: lane0 writes addr 3 = 64'hA5, lane1 writes addr 7 = 64'h5A in cycle N → in N+1 WEnb=2'b11 with those addr/data. RAddr port0=3 in N+1 → RData[0]=64'hA5 via forwarding; in N+2 it reads the same value from RDataMem.
3. Collision: both lanes addr 5, data 11/22 → N+1 WEnb=2'b10 with data 22; collision_cnt 0→1. Repeat 65536 times → count saturates at 16'hFFFF.
4. clear_req with lane0 valid in the same cycle → lane_ready=0, no write of lane0. Next cycle busy=1 and clr_cnt=0; 16 zero writes follow.
5. rst asserted when clr_cnt=9 → outputs immediately 0. After release, the clear restarts at address 0 and runs the full 16 cycles.
6. INIT_CLEAR=0 → busy=0 and lane_ready=1 the first cycle after reset; no zero writes issued.
